// File: rtl/alu_ops_pkg.sv
// Shared ALU definitions: opcode constants, arbiter FSM states and the {N,Z,V,C} flag layout.
package alu_ops;

  localparam logic [3:0] ADD_OP = 4'd0;
  localparam logic [3:0] SUB_OP = 4'd1;
  localparam logic [3:0] AND_OP = 4'd2;
  localparam logic [3:0] OR_OP  = 4'd3;
  localparam logic [3:0] XOR_OP = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a tie goes to the requester that did not win last time.
module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid0 && valid1) grant = last_grant ? 2'b01 : 2'b10;
      else if (valid0)      grant = 2'b01;
      else if (valid1)      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: grant, execute, then hold the response.
module alu_arbiter
  import alu_ops::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_opcode,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_opcode,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] alu_opcode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_negative,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  input  logic         alu_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [3:0]   status_flags,
  output logic         busy
);

  arb_state_t   state;
  logic         last_grant;
  logic         arb_en;
  logic [1:0]   grant;
  logic [W-1:0] op_p0, a_p0, b_p0;
  logic [W-1:0] res_p1;
  logic [3:0]   flags_p1;
  logic         id_p1;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  assign arb_en = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));

  rr_arbiter2 u_rr (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .enable     (arb_en),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      if (|grant) last_grant <= grant[1];
      case (state)
        IDLE:    if (|grant) state <= EXEC;
        EXEC:    state <= RESP;
        RESP:    if (rsp_ready) state <= (|grant) ? EXEC : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: operands of the granted request, held until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
    end else if (|grant) begin
      op_p0 <= grant[1] ? req1_opcode : req0_opcode;
      a_p0  <= grant[1] ? req1_a      : req0_a;
      b_p0  <= grant[1] ? req1_b      : req0_b;
    end
  end

  assign alu_opcode = op_p0;
  assign alu_a      = a_p0;
  assign alu_b      = b_p0;

  // Stage p1: ALU outputs captured once, in EXEC, and held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1       <= '0;
      flags_p1     <= 4'b0000;
      id_p1        <= 1'b0;
      status_flags <= 4'b0000;
    end else if (state == EXEC) begin
      res_p1       <= alu_result;
      flags_p1     <= pack_flags(alu_negative, alu_zero, alu_overflow, alu_cout);
      id_p1        <= last_grant;
      status_flags <= pack_flags(alu_negative, alu_zero, alu_overflow, alu_cout);
    end
  end

  assign rsp_id     = id_p1;
  assign rsp_result = res_p1;
  assign rsp_flags  = flags_p1;

endmodule
